// File: rtl/prefetch_sched.sv
// Instruction-fetch request sequencer in front of the prefetch FIFO.
// Tracks the linear fetch address and the CS-limit budget, and issues line-bounded reads or one fault marker per redirect.
module prefetch_sched #(
    parameter int FIFO_HIGH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pr_reset_i,
    input  logic [31:0] cs_base_i,
    input  logic [31:0] cs_limit_i,
    input  logic [31:0] eip_i,
    input  logic [4:0]  prefetchfifo_used_i,
    output logic        req_do_o,
    output logic [31:0] req_address_o,
    output logic [4:0]  req_length_o,
    input  logic        req_done_i,
    input  logic        req_pf_i,
    output logic        prefetchfifo_signal_limit_do_o,
    output logic        prefetchfifo_signal_pf_do_o
);

    typedef enum logic [1:0] {STOPPED, ISSUE, WAIT, FAULTED} state_t;

    localparam logic [5:0] HIGH_MARK = 6'(FIFO_HIGH);

    state_t      state_q;
    logic [31:0] linear_q;
    logic [32:0] remaining_q;
    logic        req_do_q;
    logic [31:0] req_address_q;
    logic [4:0]  req_length_q;
    logic        limit_do_q;
    logic        pf_do_q;

    logic [4:0]  chunk_d;
    logic        fifo_room_d;

    // Bytes left up to the next 16-byte line boundary, clipped to the limit budget.
    function automatic logic [4:0] line_chunk(input logic [3:0] offset, input logic [32:0] rem);
        logic [4:0] room;
        room = 5'd16 - {1'b0, offset};
        if (rem < {28'd0, room})
            line_chunk = rem[4:0];
        else
            line_chunk = room;
    endfunction

    // Inclusive byte count from eip to the limit; a full 4 GiB segment needs the 33rd bit.
    function automatic logic [32:0] limit_span(input logic [31:0] eip, input logic [31:0] limit);
        if (eip > limit)
            limit_span = '0;
        else
            limit_span = {1'b0, limit} - {1'b0, eip} + 33'd1;
    endfunction

    always_comb begin
        chunk_d     = line_chunk(linear_q[3:0], remaining_q);
        fifo_room_d = !prefetchfifo_used_i[4] && ({1'b0, prefetchfifo_used_i} < HIGH_MARK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= STOPPED;
            linear_q      <= '0;
            remaining_q   <= '0;
            req_do_q      <= 1'b0;
            req_address_q <= '0;
            req_length_q  <= '0;
            limit_do_q    <= 1'b0;
            pf_do_q       <= 1'b0;
        end else begin
            limit_do_q <= 1'b0;
            pf_do_q    <= 1'b0;
            if (pr_reset_i) begin
                linear_q    <= cs_base_i + eip_i;
                remaining_q <= limit_span(eip_i, cs_limit_i);
                req_do_q    <= 1'b0;
                state_q     <= ISSUE;
            end else begin
                case (state_q)
                    ISSUE: begin
                        if (remaining_q == '0) begin
                            limit_do_q <= 1'b1;
                            state_q    <= FAULTED;
                        end else if (fifo_room_d) begin
                            req_do_q      <= 1'b1;
                            req_address_q <= linear_q;
                            req_length_q  <= chunk_d;
                            state_q       <= WAIT;
                        end
                    end
                    WAIT: begin
                        // A page fault outranks a completion reported in the same cycle.
                        if (req_pf_i) begin
                            req_do_q <= 1'b0;
                            pf_do_q  <= 1'b1;
                            state_q  <= FAULTED;
                        end else if (req_done_i) begin
                            req_do_q    <= 1'b0;
                            linear_q    <= linear_q + {27'd0, req_length_q};
                            remaining_q <= remaining_q - {28'd0, req_length_q};
                            state_q     <= ISSUE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_do_o                       = req_do_q;
    assign req_address_o                  = req_address_q;
    assign req_length_o                   = req_length_q;
    assign prefetchfifo_signal_limit_do_o = limit_do_q;
    assign prefetchfifo_signal_pf_do_o    = pf_do_q;

endmodule

// File: tb/tb_prefetch_sched.sv
// Scoreboard bench for prefetch_sched: a request/marker model fills a queue, a monitor pops on every DUT event.
module tb_prefetch_sched;

    localparam int FH = 8;
    localparam int K_REQ = 0;
    localparam int K_LIMIT = 1;
    localparam int K_PF = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pr_reset_i;
    logic [31:0] cs_base_i;
    logic [31:0] cs_limit_i;
    logic [31:0] eip_i;
    logic [4:0]  fifo_used_i;
    logic        req_do_o;
    logic [31:0] req_address_o;
    logic [4:0]  req_length_o;
    logic        req_done_i;
    logic        req_pf_i;
    logic        limit_do_o;
    logic        pf_do_o;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    int   first_req_cyc;
    int   limit_cyc;

    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [4:0]  prev_len = '0;

    prefetch_sched #(.FIFO_HIGH(FH)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .pr_reset_i                     (pr_reset_i),
        .cs_base_i                      (cs_base_i),
        .cs_limit_i                     (cs_limit_i),
        .eip_i                          (eip_i),
        .prefetchfifo_used_i            (fifo_used_i),
        .req_do_o                       (req_do_o),
        .req_address_o                  (req_address_o),
        .req_length_o                   (req_length_o),
        .req_done_i                     (req_done_i),
        .req_pf_i                       (req_pf_i),
        .prefetchfifo_signal_limit_do_o (limit_do_o),
        .prefetchfifo_signal_pf_do_o    (pf_do_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_evt(input int kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d (addr 0x%0h), expected nothing", kind, req_address_o);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", longint'(kind), longint'(e.kind));
            if (kind == K_REQ && e.kind == K_REQ) begin
                chk("req_address", longint'(req_address_o), longint'(e.addr));
                chk("req_length", longint'(req_length_o), longint'(e.len));
            end
        end
    endtask

    // Reference: walk the fetch stream in line-sized chunks until the byte budget, a fault or the cap.
    task automatic model_push(input logic [31:0] base, input logic [31:0] eip, input logic [31:0] limit,
                              input int pf_at, input int cap, output int first_kind);
        logic [31:0] lin;
        longint      rem;
        int          k;
        int          len;
        exp_t        e;
        bit          first;
        lin = base + eip;
        rem = (eip > limit) ? 0 : ({32'd0, limit} - {32'd0, eip} + 64'd1);
        k = 0;
        first = 1'b1;
        first_kind = -1;
        forever begin
            if (rem == 0) begin
                e.kind = K_LIMIT; e.addr = '0; e.len = 0;
                exp_q.push_back(e);
                if (first) first_kind = K_LIMIT;
                break;
            end
            if (k == cap) break;
            len = 16 - int'(lin[3:0]);
            if (rem < longint'(len)) len = int'(rem);
            e.kind = K_REQ; e.addr = lin; e.len = len;
            exp_q.push_back(e);
            if (first) first_kind = K_REQ;
            first = 1'b0;
            k++;
            if (k == pf_at) begin
                e.kind = K_PF; e.addr = '0; e.len = 0;
                exp_q.push_back(e);
                break;
            end
            lin = lin + 32'(len);
            rem = rem - longint'(len);
        end
    endtask

    // Memory-side responder and FIFO occupancy driver; returns once the expectations drain and the DUT is quiet.
    task automatic run_loop(input int pf_at, input bit pf_done, input int cap, input int fixed_dly,
                            input int hold, input logic [4:0] hold_val, input logic [4:0] post_used);
        int served;
        int dly;
        int quiet;
        bit fired;
        served = 0; dly = -1; quiet = 0; fired = 1'b0;
        first_req_cyc = -1;
        limit_cyc = -1;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            pr_reset_i = 1'b0;
            req_done_i = 1'b0;
            req_pf_i = 1'b0;
            if (fired) begin
                chk("req_do_drop_after_resp", longint'(req_do_o), 0);
                fired = 1'b0;
            end
            if (req_do_o && first_req_cyc < 0) first_req_cyc = c;
            if (limit_do_o && limit_cyc < 0) limit_cyc = c;
            if (!req_do_o) begin
                dly = -1;
            end else begin
                if (dly == -1) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
                if (dly == 0) begin
                    served++;
                    if (served == pf_at) begin
                        req_pf_i = 1'b1;
                        req_done_i = pf_done;
                    end else begin
                        req_done_i = 1'b1;
                    end
                    dly = -2;
                    fired = 1'b1;
                end else if (dly > 0) begin
                    dly--;
                end
            end
            fifo_used_i = (served >= cap) ? 5'(FH) : ((c < hold) ? hold_val : post_used);
            if (exp_q.size() == 0 && !req_do_o) quiet++;
            else quiet = 0;
            if (quiet >= 10) break;
        end
        chk("scenario_drained", longint'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic scen(input logic [31:0] base, input logic [31:0] eip, input logic [31:0] limit,
                        input int pf_at, input bit pf_done, input int cap, input int fixed_dly,
                        input int hold, input logic [4:0] hold_val, input logic [4:0] post_used);
        int fk;
        model_push(base, eip, limit, pf_at, cap, fk);
        @(negedge clk);
        cs_base_i = base;
        eip_i = eip;
        cs_limit_i = limit;
        pr_reset_i = 1'b1;
        fifo_used_i = (hold > 0) ? hold_val : post_used;
        run_loop(pf_at, pf_done, cap, fixed_dly, hold, hold_val, post_used);
        if (fk == K_REQ) chk("first_req_latency", longint'(first_req_cyc), longint'(hold + 1));
        else if (fk == K_LIMIT) chk("limit_latency", longint'(limit_cyc), 1);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (req_do_o && !prev_req) begin
                expect_evt(K_REQ);
            end else if (req_do_o) begin
                chk("req_address_stable", longint'(req_address_o), longint'(prev_addr));
                chk("req_length_stable", longint'(req_length_o), longint'(prev_len));
            end
            if (limit_do_o) expect_evt(K_LIMIT);
            if (pf_do_o) expect_evt(K_PF);
        end
        prev_req = req_do_o;
        prev_addr = req_address_o;
        prev_len = req_length_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fk;
        int seen;
        logic [31:0] rb, re, rl;
        logic [4:0]  hv;
        rst_n = 1'b0;
        pr_reset_i = 1'b1;
        cs_base_i = 32'h1234_5670;
        cs_limit_i = 32'hFFFF;
        eip_i = 32'h10;
        fifo_used_i = '0;
        req_done_i = 1'b0;
        req_pf_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_do", longint'(req_do_o), 0);
        chk("reset_req_address", longint'(req_address_o), 0);
        chk("reset_req_length", longint'(req_length_o), 0);
        chk("reset_limit_do", longint'(limit_do_o), 0);
        chk("reset_pf_do", longint'(pf_do_o), 0);
        rst_n = 1'b1;
        pr_reset_i = 1'b0;
        mon_en = 1'b1;
        repeat (6) @(negedge clk);
        chk("stopped_idle", longint'(req_do_o), 0);

        scen(32'h1000, 32'h0, 32'hFFFF, 0, 1'b0, 3, 2, 0, 5'd8, 5'd0);
        scen(32'h0, 32'h0D, 32'hFFFF, 0, 1'b0, 2, -1, 0, 5'd8, 5'd0);
        scen(32'h0, 32'h0, 32'h13, 0, 1'b0, 100, -1, 0, 5'd8, 5'd0);
        scen(32'h0, 32'h20, 32'h1F, 0, 1'b0, 100, -1, 0, 5'd8, 5'd0);
        scen(32'h0, 32'h0, 32'hFFFF, 2, 1'b0, 100, 1, 0, 5'd8, 5'd0);
        scen(32'h40, 32'h3, 32'hFFFF, 1, 1'b1, 100, 0, 0, 5'd8, 5'd0);
        scen(32'h0, 32'h0, 32'h2F, 0, 1'b0, 100, -1, 10, 5'd8, 5'd7);
        scen(32'h0, 32'h5, 32'h2F, 0, 1'b0, 100, -1, 6, 5'd16, 5'd7);
        scen(32'hFFFF_FFF0, 32'h8, 32'h27, 0, 1'b0, 100, -1, 0, 5'd8, 5'd3);
        scen(32'h0, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, 2, -1, 0, 5'd8, 5'd0);
        scen(32'h0, 32'h7, 32'h7, 0, 1'b0, 100, -1, 0, 5'd8, 5'd0);

        // Redirect lands in the same cycle as the completion of the request it aborts.
        model_push(32'h0, 32'h100, 32'hFFFF, 0, 1, fk);
        @(negedge clk);
        cs_base_i = 32'h0;
        eip_i = 32'h100;
        cs_limit_i = 32'hFFFF;
        fifo_used_i = '0;
        pr_reset_i = 1'b1;
        @(negedge clk);
        pr_reset_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (req_do_o) seen = 1;
            else @(negedge clk);
        end
        chk("redirect_req_seen", longint'(req_do_o), 1);
        model_push(32'h0, 32'h205, 32'h20F, 0, 100, fk);
        eip_i = 32'h205;
        cs_limit_i = 32'h20F;
        pr_reset_i = 1'b1;
        req_done_i = 1'b1;
        @(negedge clk);
        pr_reset_i = 1'b0;
        req_done_i = 1'b0;
        chk("redirect_abort_req_do", longint'(req_do_o), 0);
        run_loop(0, 1'b0, 100, -1, 0, 5'd8, 5'd0);

        for (int s = 0; s < 30; s++) begin
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFE0 + 32'($urandom_range(0, 31));
            re = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 64)) : $urandom;
            case ($urandom_range(0, 3))
                0: rl = re - 32'($urandom_range(1, 20));
                default: rl = re + 32'($urandom_range(0, 90));
            endcase
            case ($urandom_range(0, 3))
                0: hv = 5'd8;
                1: hv = 5'd12;
                2: hv = 5'd16;
                default: hv = 5'd31;
            endcase
            scen(rb, re, rl, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 8)), -1,
                 int'($urandom_range(0, 4)), hv, 5'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
